// File: rtl/instruction_sequencer.sv
`default_nettype none
// instruction_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with sticky status flags.
// Defining SEQ_MEM_TIMEOUT_EN adds a MEM wait-state limit of TIMEOUT_CYCLES that aborts to WB with timeout_err.
module instruction_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] i_instruction,
   input  logic        i_mem_ready,
   output logic        o_pc_en,
   output logic [31:0] o_ir,
   output logic [5:0]  o_opcode,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [31:0] o_imm_ext,
   output logic [3:0]  o_alu_op,
   output logic        o_reg_we,
   output logic        o_mem_rd,
   output logic        o_mem_wr,
   output logic [2:0]  o_state,
   output logic        o_halted,
   output logic        o_illegal_err,
   output logic        o_timeout_err
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [5:0] c_OP_RTYPE = 6'h00;
   localparam logic [5:0] c_OP_ADDI  = 6'h01;
   localparam logic [5:0] c_OP_LW    = 6'h02;
   localparam logic [5:0] c_OP_SW    = 6'h03;
   localparam logic [5:0] c_OP_HALT  = 6'h3F;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must lie in 2..255");
   end

   state_t      r_state;
   state_t      w_next_state;
   logic [31:0] r_ir;
   logic        r_halted;
   logic        r_illegal;
   logic        w_set_halt;
   logic        w_set_illegal;
   logic        w_timeout;
   logic        w_tmo_wb;
   logic        w_is_rtype;
   logic        w_is_addi;
   logic        w_is_lw;
   logic        w_is_sw;
   logic        w_is_halt;
   logic        w_in_flight;

   assign o_ir      = r_ir;
   assign o_opcode  = r_ir[31:26];
   assign o_rd      = r_ir[25:21];
   assign o_rs1     = r_ir[20:16];
   assign o_rs2     = r_ir[15:11];
   assign o_imm_ext = {{16{r_ir[15]}}, r_ir[15:0]};

   assign w_is_rtype = (o_opcode == c_OP_RTYPE);
   assign w_is_addi  = (o_opcode == c_OP_ADDI);
   assign w_is_lw    = (o_opcode == c_OP_LW);
   assign w_is_sw    = (o_opcode == c_OP_SW);
   assign w_is_halt  = (o_opcode == c_OP_HALT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_ir      <= 32'h0;
         r_halted  <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_FETCH) begin
            r_ir <= i_instruction;
         end
         if (w_set_halt) begin
            r_halted <= 1'b1;
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   always_comb begin
      w_next_state  = S_FETCH;
      w_set_halt    = 1'b0;
      w_set_illegal = 1'b0;
      case (r_state)
         S_FETCH:  w_next_state = S_DECODE;
         S_DECODE: begin
            if (w_is_rtype || w_is_addi || w_is_lw || w_is_sw) begin
               w_next_state = S_EXEC;
            end else if (w_is_halt) begin
               w_next_state = S_HALT;
               w_set_halt   = 1'b1;
            end else begin
               w_next_state  = S_WB;
               w_set_illegal = 1'b1;
            end
         end
         S_EXEC:   w_next_state = (w_is_lw || w_is_sw) ? S_MEM : S_WB;
         S_MEM:    w_next_state = (i_mem_ready || w_timeout) ? S_WB : S_MEM;
         S_WB:     w_next_state = S_FETCH;
         S_HALT:   w_next_state = S_HALT;
         default:  w_next_state = S_FETCH;
      endcase
   end

   // Only LW/SW ever reach MEM, so the read and write strobes are exclusive by construction.
   assign w_in_flight   = (r_state == S_DECODE) || (r_state == S_EXEC) ||
                          (r_state == S_MEM) || (r_state == S_WB);
   assign o_alu_op      = (w_in_flight && w_is_rtype) ? r_ir[3:0] : 4'h0;
   assign o_pc_en       = (r_state == S_WB);
   assign o_reg_we      = (r_state == S_WB) && (w_is_rtype || w_is_addi || w_is_lw) && !w_tmo_wb;
   assign o_mem_rd      = (r_state == S_MEM) && w_is_lw;
   assign o_mem_wr      = (r_state == S_MEM) && w_is_sw;
   assign o_state       = r_state;
   assign o_halted      = r_halted;
   assign o_illegal_err = r_illegal;

`ifdef SEQ_MEM_TIMEOUT_EN
   localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT_CYCLES);

   logic [7:0] r_tmo_cnt;
   logic       r_tmo_err;
   logic       r_tmo_wb;

   // Fires on the MEM cycle whose low mem_ready would bring the count to the limit.
   assign w_timeout = (r_state == S_MEM) && !i_mem_ready && ((r_tmo_cnt + 8'd1) == c_TIMEOUT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo_cnt <= 8'd0;
         r_tmo_err <= 1'b0;
         r_tmo_wb  <= 1'b0;
      end else begin
         if (r_state == S_EXEC) begin
            r_tmo_cnt <= 8'd0;
         end else if ((r_state == S_MEM) && !i_mem_ready) begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
         end
         if (w_timeout) begin
            r_tmo_err <= 1'b1;
            r_tmo_wb  <= 1'b1;
         end else if (r_state == S_FETCH) begin
            r_tmo_wb  <= 1'b0;
         end
      end
   end

   assign w_tmo_wb      = r_tmo_wb;
   assign o_timeout_err = r_tmo_err;
`else
   assign w_timeout     = 1'b0;
   assign w_tmo_wb      = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_sequencer.sv
`default_nettype none
// tb_instruction_sequencer: each instruction is expanded into its expected per-cycle outputs,
// which one negedge process drives and compares; directed literals pin latency, strobes and fields.
module tb_instruction_sequencer;

`ifdef SEQ_MEM_TIMEOUT_EN
   localparam int c_TMO    = 4;
   localparam bit c_TMO_EN = 1'b1;
`else
   localparam int c_TMO    = 16;
   localparam bit c_TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] i_instruction;
   logic        i_mem_ready;
   logic        o_pc_en;
   logic [31:0] o_ir;
   logic [5:0]  o_opcode;
   logic [4:0]  o_rd, o_rs1, o_rs2;
   logic [31:0] o_imm_ext;
   logic [3:0]  o_alu_op;
   logic        o_reg_we, o_mem_rd, o_mem_wr;
   logic [2:0]  o_state;
   logic        o_halted, o_illegal_err, o_timeout_err;

   instruction_sequencer #(.TIMEOUT_CYCLES(c_TMO)) dut (
      .clk(clk), .rst_n(rst_n), .i_instruction(i_instruction), .i_mem_ready(i_mem_ready),
      .o_pc_en(o_pc_en), .o_ir(o_ir), .o_opcode(o_opcode), .o_rd(o_rd), .o_rs1(o_rs1),
      .o_rs2(o_rs2), .o_imm_ext(o_imm_ext), .o_alu_op(o_alu_op), .o_reg_we(o_reg_we),
      .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_state(o_state), .o_halted(o_halted),
      .o_illegal_err(o_illegal_err), .o_timeout_err(o_timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] ins;
      logic        rdy;
      logic [2:0]  st;
      logic        pc, we, rd, wr;
      logic        halt, ill, tmo;
      logic [31:0] ir;
   } cyc_t;

   cyc_t q[$];
   bit   busy = 1'b0;
   int   n_cmp = 0, n_bad = 0;
   int   n_pc = 0, n_we = 0, n_rd = 0, n_wr = 0;
   int   b_pc, b_we, b_rd, b_wr;
   int   cyc_since_fetch = 0, last_lat = 0;
   logic [3:0]  dec_alu = 4'h0;
   logic [31:0] dec_imm = 32'h0;

   // Architectural view of what the sequencer has seen so far.
   logic [31:0] m_ir   = 32'h0;
   logic        m_halt = 1'b0, m_ill = 1'b0, m_tmo = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic finish_up();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   task automatic push(input logic [31:0] ins, input logic rdy, input logic [2:0] st,
                       input logic we, input logic rd, input logic wr);
      cyc_t c;
      c.ins  = ins;   c.rdy = rdy;   c.st = st;
      c.pc   = (st == 3'd4);
      c.we   = we;    c.rd  = rd;    c.wr = wr;
      c.halt = m_halt; c.ill = m_ill; c.tmo = m_tmo;
      c.ir   = m_ir;
      q.push_back(c);
   endtask

   task automatic add_instr(input logic [31:0] ins, input int n_low);
      logic [5:0] op;
      bit rtype, addi, lw, sw, legal, hit;
      op    = ins[31:26];
      rtype = (op == 6'h00); addi = (op == 6'h01);
      lw    = (op == 6'h02); sw   = (op == 6'h03);
      legal = rtype || addi || lw || sw;
      hit   = 1'b0;
      push(ins, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      m_ir = ins;
      push(~ins, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
      if (op == 6'h3F) begin
         m_halt = 1'b1;
         for (int i = 0; i < 20; i++) push(~ins, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0);
         return;
      end
      if (!legal) begin
         m_ill = 1'b1;
         push(~ins, 1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
         return;
      end
      push(~ins, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
      if (lw || sw) begin
         if (c_TMO_EN && n_low >= c_TMO) begin
            for (int i = 0; i < c_TMO; i++) push(~ins, 1'b0, 3'd3, 1'b0, lw, sw);
            m_tmo = 1'b1;
            hit   = 1'b1;
         end else begin
            for (int i = 0; i < n_low; i++) push(~ins, 1'b0, 3'd3, 1'b0, lw, sw);
            push(~ins, 1'b1, 3'd3, 1'b0, lw, sw);
         end
      end
      push(~ins, 1'b1, 3'd4, (rtype || addi || lw) && !hit, 1'b0, 1'b0);
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((q.size() != 0 || busy) && k < 5000) begin
         @(posedge clk);
         k++;
      end
      if (k >= 5000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expected cycles left unconsumed, required 0", q.size());
         finish_up();
      end
   endtask

   task automatic snap();
      b_pc = n_pc; b_we = n_we; b_rd = n_rd; b_wr = n_wr;
   endtask

   initial begin : compare
      cyc_t cur;
      logic [3:0] exp_alu;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            busy = 1'b1;
            cur  = q.pop_front();
            i_instruction = cur.ins;
            i_mem_ready   = cur.rdy;
            #1;
            exp_alu = (cur.st >= 3'd1 && cur.st <= 3'd4 && cur.ir[31:26] == 6'h00) ? cur.ir[3:0] : 4'h0;
            chk("state",   o_state,   cur.st);
            chk("ir",      o_ir,      cur.ir);
            chk("opcode",  o_opcode,  cur.ir[31:26]);
            chk("rd",      o_rd,      cur.ir[25:21]);
            chk("rs1",     o_rs1,     cur.ir[20:16]);
            chk("rs2",     o_rs2,     cur.ir[15:11]);
            chk("imm_ext", o_imm_ext, 32'($signed(cur.ir[15:0])));
            chk("alu_op",  o_alu_op,  exp_alu);
            chk("pc_en",   o_pc_en,   cur.pc);
            chk("reg_we",  o_reg_we,  cur.we);
            chk("mem_rd",  o_mem_rd,  cur.rd);
            chk("mem_wr",  o_mem_wr,  cur.wr);
            chk("halted",  o_halted,  cur.halt);
            chk("illegal", o_illegal_err, cur.ill);
            chk("timeout", o_timeout_err, cur.tmo);
            if (o_pc_en)  n_pc++;
            if (o_reg_we) n_we++;
            if (o_mem_rd) n_rd++;
            if (o_mem_wr) n_wr++;
            cyc_since_fetch = (o_state == 3'd0) ? 1 : cyc_since_fetch + 1;
            if (o_pc_en) last_lat = cyc_since_fetch;
            if (o_state == 3'd1) begin
               dec_alu = o_alu_op;
               dec_imm = o_imm_ext;
            end
            busy = 1'b0;
         end
      end
   end

   initial begin : stimulus
      rst_n = 1'b0;
      i_instruction = 32'h0;
      i_mem_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_state", o_state, 3'd0);
      chk("rst_ir", o_ir, 32'h0);
      chk("rst_pc_en", o_pc_en, 1'b0);
      chk("rst_flags", {o_halted, o_illegal_err, o_timeout_err}, 3'b000);
      chk("rst_strobes", {o_reg_we, o_mem_rd, o_mem_wr}, 3'b000);
      #1 rst_n = 1'b1;

      snap(); add_instr(32'h0022_1802, 0); drain();
      chk("rtype_alu", dec_alu, 4'h2);
      chk("rtype_lat", last_lat, 4);
      chk("rtype_we_cnt", n_we - b_we, 1);
      chk("rtype_pc_cnt", n_pc - b_pc, 1);

      add_instr(32'h0043_2807, 0); drain();
      chk("rtype2_alu", dec_alu, 4'h7);

      snap(); add_instr(32'h0461_FFFC, 0); drain();
      chk("addi_imm", dec_imm, 32'hFFFF_FFFC);
      chk("addi_alu", dec_alu, 4'h0);
      chk("addi_lat", last_lat, 4);
      chk("addi_we_cnt", n_we - b_we, 1);

      snap(); add_instr(32'h08A2_0010, 0); drain();
      chk("lw_imm", dec_imm, 32'h0000_0010);
      chk("lw_lat", last_lat, 5);
      chk("lw_rd_cnt", n_rd - b_rd, 1);

      snap(); add_instr(32'h08C3_0008, 3); drain();
      chk("lwwait_rd_cnt", n_rd - b_rd, 4);
      chk("lwwait_lat", last_lat, 8);
      chk("lwwait_we_cnt", n_we - b_we, 1);

      snap(); add_instr(32'h0CE4_8004, 0); drain();
      chk("sw_wr_cnt", n_wr - b_wr, 1);
      chk("sw_we_cnt", n_we - b_we, 0);
      chk("sw_pc_cnt", n_pc - b_pc, 1);
      chk("sw_lat", last_lat, 5);

      snap(); add_instr(32'hA800_1234, 0); drain();
      chk("ill_pc_cnt", n_pc - b_pc, 1);
      chk("ill_we_cnt", n_we - b_we, 0);
      chk("ill_flag", o_illegal_err, 1'b1);

      // LW aborted by reset while waiting in MEM.
      snap();
      push(32'h0821_0040, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
      m_ir = 32'h0821_0040;
      push(32'h1111_1111, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
      push(32'h1111_1111, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0);
      push(32'h1111_1111, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
      push(32'h1111_1111, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
      drain();
      #2;
      chk("abort_pre_state", o_state, 3'd3);
      chk("abort_pre_rd", o_mem_rd, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("abort_state", o_state, 3'd0);
      chk("abort_rd", o_mem_rd, 1'b0);
      chk("abort_ir", o_ir, 32'h0);
      chk("abort_ill_cleared", o_illegal_err, 1'b0);
      chk("abort_no_wb", n_pc - b_pc, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      m_ir = 32'h0; m_ill = 1'b0; m_tmo = 1'b0; m_halt = 1'b0;

      snap(); add_instr(32'h0CE4_0004, 0); drain();
      chk("post_rst_sw_lat", last_lat, 5);

      snap(); add_instr(32'h0842_0004, 20); drain();
`ifdef SEQ_MEM_TIMEOUT_EN
      chk("tmo_rd_cnt", n_rd - b_rd, 4);
      chk("tmo_we_cnt", n_we - b_we, 0);
      chk("tmo_flag", o_timeout_err, 1'b1);
`else
      chk("longwait_rd_cnt", n_rd - b_rd, 21);
      chk("longwait_we_cnt", n_we - b_we, 1);
      chk("no_tmo_flag", o_timeout_err, 1'b0);
`endif
      chk("tmo_pc_cnt", n_pc - b_pc, 1);

      snap(); add_instr(32'hFC00_0000, 0); drain();
      chk("halt_pc_cnt", n_pc - b_pc, 0);
      chk("halt_we_cnt", n_we - b_we, 0);
      chk("halt_flag", o_halted, 1'b1);

      finish_up();
   end

endmodule
`default_nettype wire

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 16, is the MEM-state wait limit in cycles, range 2..255; it is used only when SEQ_MEM_TIMEOUT_EN is defined.
REQ-002 clk  input  1  is the single clock; all state updates occur on the rising edge.
REQ-003 reset  input  1  is the reset; it is asynchronous and active-low.
REQ-004 instruction  input  32  is the fetched word from instruction memory; it is valid during FETCH.
REQ-005 mem_ready  input  1  is the data-memory completion handshake; it is sampled only in MEM.
REQ-006 pc_en  output  1  is a one-cycle strobe that advances the program counter by 4.
REQ-007 ir  output  32  is the latched instruction register.
REQ-008 opcode/rd/rs1/rs2  output  6/5/5/5  are fields decoded from ir: [31:26], [25:21], [20:16], [15:11].
REQ-009 imm_ext  output  32  is ir[15:0] sign-extended to 32 bits.
REQ-010 alu_op  output  4  selects the ALU operation.
REQ-011 reg_we, mem_rd, mem_wr  output  1 each  are the register-write, memory-read and memory-write strobes.
REQ-012 state  output  3  is the current FSM state encoding.
REQ-013 halted, illegal_err, timeout_err  output  1 each  are sticky status flags.

Function
REQ-014 The FSM states SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL return to FETCH on the next edge.
REQ-015 In FETCH, ir SHALL load instruction on the edge, and the FSM SHALL go to DECODE; ir SHALL hold its value in all other states.
REQ-016 DECODE SHALL go to EXEC for opcodes 0x00 (R-type), 0x01 (ADDI), 0x02 (LW) and 0x03 (SW).
REQ-017 DECODE SHALL go to HALT for opcode 0x3F.
REQ-018 DECODE SHALL handle any other opcode as illegal: it sets illegal_err and goes to WB with no strobes except pc_en.
REQ-019 EXEC SHALL go to MEM for LW or SW and to WB otherwise.
REQ-020 alu_op SHALL be ir[3:0] for R-type, 4'h0 (add) for ADDI/LW/SW, and 4'h0 otherwise; it SHALL be valid from DECODE through WB.
REQ-021 In MEM, mem_rd (LW) or mem_wr (SW) SHALL be held high each cycle until mem_ready is sampled high, and the FSM SHALL then go to WB.
REQ-022 mem_rd and mem_wr SHALL never be high together.
REQ-023 In WB, reg_we SHALL be high for one cycle for R-type, ADDI and LW, and low for SW and illegal opcodes.
REQ-024 pc_en SHALL be high for exactly the WB cycle, and the FSM SHALL then go to FETCH.
REQ-025 Instruction latency without memory wait states SHALL be 4 cycles for R-type and ADDI, and 5 cycles for LW and SW plus one cycle per mem_ready-low cycle.
REQ-026 HALT SHALL be absorbing: halted=1, pc_en=0, all strobes low, ir frozen, until reset.
REQ-027 Decoded outputs (opcode, rd, rs1, rs2, imm_ext) SHALL be combinational functions of ir only.
REQ-028 Status flags SHALL be set-only; only reset clears them.

Reset
REQ-029 On assertion of reset (low), the following SHALL take effect immediately regardless of clk: state=FETCH, ir=32'h0, pc_en/reg_we/mem_rd/mem_wr=0, halted/illegal_err/timeout_err=0, and the timeout counter=0.
REQ-030 Reset asserted mid-MEM SHALL drop mem_rd and mem_wr asynchronously, and no WB SHALL occur for the aborted instruction.
REQ-031 The first FETCH SHALL occur on the first rising edge after reset deasserts.

Configuration
REQ-032 Macro SEQ_MEM_TIMEOUT_EN: when defined, an 8-bit counter SHALL clear on MEM entry and increment each MEM cycle with mem_ready low.
REQ-033 When that counter reaches TIMEOUT_CYCLES, the FSM SHALL set timeout_err, drop mem_rd and mem_wr, and go to WB with reg_we suppressed and pc_en asserted.
REQ-034 When SEQ_MEM_TIMEOUT_EN is not defined, MEM SHALL wait indefinitely, no counter logic SHALL exist, and timeout_err SHALL be tied to 0.

Verification
REQ-035 Release reset; instruction=0x0022_1802 (R-type, alu_op=2), mem_ready=1 -> states 0,1,2,4; reg_we and pc_en high in cycle 4 only; alu_op=4'h2.
REQ-036 ADDI with ir[15:0]=0xFFFC -> imm_ext=0xFFFF_FFFC; LW with imm 0x0010 -> imm_ext=0x0000_0010.
REQ-037 LW with mem_ready low for 3 MEM cycles -> mem_rd high 4 cycles; WB on the 5th cycle after EXEC; reg_we=1; latency 8.
REQ-038 SW with mem_ready=1 -> mem_wr high for 1 cycle; reg_we=0 in WB; pc_en=1.
REQ-039 Opcode 0x3F -> halted=1 and pc_en stays 0 for 20 cycles; opcode 0x2A -> illegal_err=1, pc_en pulses once, reg_we=0.
REQ-040 Macro defined, TIMEOUT_CYCLES=4, LW with mem_ready held low -> timeout_err=1 after 4 MEM cycles; WB with reg_we=0; reset mid-MEM -> state=0 and mem_rd=0 without a clock edge.
